// File: rtl/neurosync_pkg.sv
// Shared definitions for the NeuroSync button conditioner: FSM state encoding,
// default debounce/long-press timings and button channel indices.
package neurosync_pkg;

  typedef enum logic [1:0] {
    SOLTO       = 2'b00,
    CONF_PRESS  = 2'b01,
    PRESSIONADO = 2'b10,
    CONF_SOLTO  = 2'b11
  } estado_t;

  localparam int unsigned DEBOUNCE_CICLOS_PADRAO = 50000;
  localparam int unsigned LONGO_CICLOS_PADRAO    = 2000000;

  localparam int unsigned BTN_JOGAR    = 0;
  localparam int unsigned BTN_CONFIRMA = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/neurosync_debounce_canal.sv
// One button channel: two-flop synchronizer, debounce FSM with saturating counter,
// registered press/level/long-press outputs. Long press enabled by NEUROSYNC_BTN_LONGO_EN.
module neurosync_debounce_canal
  import neurosync_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int unsigned LONGO_CICLOS    = LONGO_CICLOS_PADRAO
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_botao,
  output logic o_det,
  output logic o_nivel,
  output logic o_longo
);

`ifdef NEUROSYNC_BTN_LONGO_EN
  localparam int unsigned CNT_MAX = max_u(DEBOUNCE_CICLOS, LONGO_CICLOS);
`else
  localparam int unsigned CNT_MAX = DEBOUNCE_CICLOS;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_FIM = CNT_W'(DEBOUNCE_CICLOS);
  localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

  if (DEBOUNCE_CICLOS < 2 || LONGO_CICLOS <= DEBOUNCE_CICLOS) begin : g_param_invalido
    $error("neurosync_debounce_canal: DEBOUNCE_CICLOS must be >= 2 and below LONGO_CICLOS");
  end

  logic             r_s1, r_s2;
  estado_t          r_estado, w_estado_prox;
  logic [CNT_W-1:0] r_cnt, w_cnt_prox;
  logic             r_det, w_det_prox;
  logic             r_nivel, w_nivel_prox;

`ifdef NEUROSYNC_BTN_LONGO_EN
  localparam logic [CNT_W-1:0] LONGO_FIM = CNT_W'(LONGO_CICLOS);
  localparam logic [CNT_W-1:0] LONGO_PRE = CNT_W'(LONGO_CICLOS - 1);
  logic             r_longo, w_longo_prox;
  logic [CNT_W-1:0] r_cnt_salvo, w_salvo_prox;
`endif

  // Synchronizer, state and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_estado <= SOLTO;
      r_cnt    <= '0;
      r_det    <= 1'b0;
      r_nivel  <= 1'b0;
    end else begin
      r_s1     <= i_botao;
      r_s2     <= r_s1;
      r_estado <= w_estado_prox;
      r_cnt    <= w_cnt_prox;
      r_det    <= w_det_prox;
      r_nivel  <= w_nivel_prox;
    end
  end

`ifdef NEUROSYNC_BTN_LONGO_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_longo     <= 1'b0;
      r_cnt_salvo <= '0;
    end else begin
      r_longo     <= w_longo_prox;
      r_cnt_salvo <= w_salvo_prox;
    end
  end
`endif

  // Next-state and next-output logic
  always_comb begin
    w_estado_prox = r_estado;
    w_cnt_prox    = r_cnt;
    w_det_prox    = 1'b0;
`ifdef NEUROSYNC_BTN_LONGO_EN
    w_longo_prox  = 1'b0;
    w_salvo_prox  = r_cnt_salvo;
`endif
    case (r_estado)
      SOLTO: begin
        if (r_s2) begin
          w_estado_prox = CONF_PRESS;
          w_cnt_prox    = CNT_UM;
        end else begin
          w_cnt_prox    = '0;
        end
      end
      CONF_PRESS: begin
        if (!r_s2) begin
          w_estado_prox = SOLTO;
          w_cnt_prox    = '0;
        end else if (r_cnt == DEB_FIM) begin
          w_estado_prox = PRESSIONADO;
          w_cnt_prox    = '0;
          w_det_prox    = 1'b1;
        end else begin
          w_cnt_prox    = r_cnt + CNT_UM;
        end
      end
      PRESSIONADO: begin
        if (!r_s2) begin
          w_estado_prox = CONF_SOLTO;
          w_cnt_prox    = CNT_UM;
`ifdef NEUROSYNC_BTN_LONGO_EN
          w_salvo_prox  = r_cnt;
`endif
        end else begin
`ifdef NEUROSYNC_BTN_LONGO_EN
          // Long-press count saturates at LONGO_FIM so the pulse fires once per press
          if (r_cnt != LONGO_FIM) w_cnt_prox = r_cnt + CNT_UM;
          w_longo_prox = (r_cnt == LONGO_PRE);
`else
          w_cnt_prox = '0;
`endif
        end
      end
      CONF_SOLTO: begin
        if (r_s2) begin
          w_estado_prox = PRESSIONADO;
`ifdef NEUROSYNC_BTN_LONGO_EN
          w_cnt_prox    = r_cnt_salvo;
`else
          w_cnt_prox    = '0;
`endif
        end else if (r_cnt == DEB_FIM) begin
          w_estado_prox = SOLTO;
          w_cnt_prox    = '0;
        end else begin
          w_cnt_prox    = r_cnt + CNT_UM;
        end
      end
      default: begin
        w_estado_prox = SOLTO;
        w_cnt_prox    = '0;
      end
    endcase
    w_nivel_prox = (w_estado_prox == PRESSIONADO) || (w_estado_prox == CONF_SOLTO);
  end

  assign o_det   = r_det;
  assign o_nivel = r_nivel;
`ifdef NEUROSYNC_BTN_LONGO_EN
  assign o_longo = r_longo;
`else
  assign o_longo = 1'b0;
`endif

endmodule

// File: rtl/neurosync_botoes_condicionador.sv
// NeuroSync push-button conditioner: polarity, then one debounce channel per button.
// Long-press pulses are built only when NEUROSYNC_BTN_LONGO_EN is defined.
module neurosync_botoes_condicionador
  import neurosync_pkg::*;
#(
  parameter int unsigned N_BOTOES        = 2,
  parameter int unsigned DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO,
  parameter int unsigned LONGO_CICLOS    = LONGO_CICLOS_PADRAO,
  parameter bit          ATIVO_BAIXO     = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [N_BOTOES-1:0] botoes_in,
  output logic [N_BOTOES-1:0] det,
  output logic [N_BOTOES-1:0] nivel,
  output logic [N_BOTOES-1:0] longo
);

  // Internally 1 = pressed regardless of board wiring
  logic [N_BOTOES-1:0] w_pressionado;
  assign w_pressionado = ATIVO_BAIXO ? ~botoes_in : botoes_in;

  for (genvar g = 0; g < N_BOTOES; g++) begin : g_canal
    neurosync_debounce_canal #(
      .DEBOUNCE_CICLOS (DEBOUNCE_CICLOS),
      .LONGO_CICLOS    (LONGO_CICLOS)
    ) u_canal (
      .clock   (clock),
      .reset_n (reset_n),
      .i_botao (w_pressionado[g]),
      .o_det   (det[g]),
      .o_nivel (nivel[g]),
      .o_longo (longo[g])
    );
  end

endmodule

// File: doc/neurosync_botoes_condicionador.md
# neurosync_botoes_condicionador

Conditions the raw board push-buttons (jogar, confirma) for the NeuroSync game controller. Each channel is synchronized, debounced, and converted into a single-cycle press pulse. The pulses drive the controller's `jogar_det` and `confirma_det` inputs directly. The block sits between the FPGA pins and the control unit and is the only place where button timing is handled.

## Interface

Parameters:
- `N_BOTOES`, default 2: number of button channels; bit 0 = jogar, bit 1 = confirma.
- `DEBOUNCE_CICLOS`, default 50000: consecutive stable cycles required to accept a level change; legal range ≥ 2.
- `LONGO_CICLOS`, default 2000000: cycles held in the pressed state before a long-press pulse; must exceed `DEBOUNCE_CICLOS`.
- `ATIVO_BAIXO`, default 1: 1 = a raw pin reads 0 when the button is pressed.

Ports:
- `clock` in 1: single system clock; all state is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `botoes_in` in N_BOTOES: raw, asynchronous button pins.
- `det` out N_BOTOES: one-cycle pulse per accepted press.
- `nivel` out N_BOTOES: debounced pressed level, 1 = pressed.
- `longo` out N_BOTOES: one-cycle long-press pulse; tied to 0 when the feature is compiled out.

## Operation

- Polarity: each pin is inverted when `ATIVO_BAIXO`=1, so internally 1 = pressed.
- Synchronizer: two-flop synchronizer per channel (`s1`, `s2`). The FSM reads only `s2`.
- Per-channel FSM states: `SOLTO`, `CONF_PRESS`, `PRESSIONADO`, `CONF_SOLTO`. Each channel has a counter of width clog2(max(DEBOUNCE_CICLOS, LONGO_CICLOS)+1), saturating.
- `SOLTO`:
  - `s2`=1 → `CONF_PRESS`, cnt=1.
  - Otherwise stay, cnt=0.
- `CONF_PRESS`:
  - `s2`=0 → `SOLTO`, cnt=0. This is a glitch: no output.
  - `s2`=1 and cnt<DEBOUNCE_CICLOS → cnt+1.
  - `s2`=1 and cnt==DEBOUNCE_CICLOS → `PRESSIONADO`, cnt=0, `det` pulses.
- `PRESSIONADO`:
  - `s2`=0 → `CONF_SOLTO`, cnt=1.
  - Otherwise cnt counts toward `LONGO_CICLOS` and saturates.
- `CONF_SOLTO`:
  - `s2`=1 → `PRESSIONADO`. The long-press counter resumes from its saved value and does not restart.
  - cnt==DEBOUNCE_CICLOS with `s2`=0 → `SOLTO`.
  - Release never produces a pulse.
- `nivel` = 1 in `PRESSIONADO` and `CONF_SOLTO`.
- `det` is a registered output, high for exactly one cycle per accepted press. One physical press gives exactly one `det`, however long it is held.
- Channels are fully independent. Simultaneous presses on both channels give simultaneous pulses.
- Reset (any time, including mid-debounce):
  - Sync flops go to the released level; FSMs go to `SOLTO`; counters go to 0.
  - `det`, `nivel`, `longo` go to 0.
  - A button held through reset deassertion is accepted as a fresh press after the normal latency.

## Timing

- Let E0 be the first edge at which a raw press is sampled into `s1`.
  - `s2`=1 after E1.
  - `CONF_PRESS` is entered at E2.
  - `det` is high during the cycle following edge E(DEBOUNCE_CICLOS+2), and low again after the next edge.
- `nivel` rises on the same edge as `det`.
- `nivel` falls DEBOUNCE_CICLOS+2 edges after the first sampled release, provided the release stays stable.
- `longo` pulses for one cycle on the edge where the `PRESSIONADO` counter reaches `LONGO_CICLOS`. It fires at most once per press.
- No combinational path exists from `botoes_in` to any output.

## Configuration

- Macro: `NEUROSYNC_BTN_LONGO_EN`.
- Defined: long-press detection is active as described above.
- Undefined:
  - `longo` is tied to 0.
  - The counter width is clog2(DEBOUNCE_CICLOS+1).
  - In `PRESSIONADO` the counter is held at 0.
- All other behaviour is identical in both builds.

## Structure

- Shared package `neurosync_pkg`:
  - FSM state encoding constants (2-bit: `SOLTO`=00, `CONF_PRESS`=01, `PRESSIONADO`=10, `CONF_SOLTO`=11).
  - Default `DEBOUNCE_CICLOS` and `LONGO_CICLOS` values.
  - Button index constants `BTN_JOGAR`=0, `BTN_CONFIRMA`=1.
- Sub-module `neurosync_debounce_canal`: one channel (synchronizer, FSM, counter, output registers). The top instantiates `N_BOTOES` copies via generate and applies polarity.

## Test plan

All scenarios use `DEBOUNCE_CICLOS`=4, `LONGO_CICLOS`=10, `ATIVO_BAIXO`=1.

- Clean press: drive pin 0 low and hold → `det[0]` high for exactly one cycle after edge E6, `nivel[0]`=1 from the same edge, `det[1]`=0 throughout.
- Bounce: pin 0 low for 3 cycles, high 1, low 2, then high → no `det`, `nivel` stays 0.
- Hold 20 cycles, then release stable → one `det`. With the macro defined, exactly one `longo` pulse, 10 edges after `det`. `nivel` falls 6 edges after the release is sampled.
- Simultaneous press on both pins on the same edge → `det`=2'b11 on the same cycle.
- Reset asserted mid-`CONF_PRESS` (cnt=2):
  - All outputs read 0 immediately, without waiting for an edge.
  - After reset deassertion with the pin still held low, `det` fires 6 edges later.
- Build without the macro and hold 20 cycles → `longo` stays 0; `det`/`nivel` timing is identical to the scenario above.
